spi_slave_gen2: RTL and testbench

SPI_SLAVE_GEN2 -- requirements
Module: spi_slave_gen2

---
 rtl/spi_slave_pkg.sv | 20 ++
 rtl/spi_tx_shifter.sv | 57 +++++
 rtl/spi_slave_gen2.sv | 122 ++++++++++++
 tb/tb_spi_slave_gen2.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared types and constants for the SPI slave block.
// Holds the controller state encoding and the 2-bit command codes carried in
// the top two bits of every frame.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  // Command field (frame bits [FRAME_W-1:FRAME_W-2]).
  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: parallel-to-serial path for read data.
// load captures a word and drives its MSB on the next cycle; while shift is
// held, one further bit goes out per cycle until DATA_W bits have been sent,
// after which bit_out returns to 0. done is high on the cycle before the edge
// that drives the final bit, so the owner can retire state on that edge.
module spi_tx_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data,
  output logic              bit_out,
  output logic              done
);

  // Counter sized like the frame counter in the top so both share one range.
  localparam int CNT_W = $clog2(DATA_W + 3);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

  logic [DATA_W-1:0] sreg;
  logic [CNT_W-1:0]  cnt;   // bits already driven; 0 when idle

  assign done = shift && (cnt == LAST - 1'b1);

  // Load, shift out MSB-first, and return to idle after the last bit.
  // NOTE: non-blocking assignments throughout so every register here sees the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sreg    <= '0;
      cnt     <= '0;
      bit_out <= 1'b0;
    end else if (clr) begin
      sreg    <= '0;
      cnt     <= '0;
      bit_out <= 1'b0;
    end else if (load) begin
      bit_out <= data[DATA_W-1];
      sreg    <= {data[DATA_W-2:0], 1'b0};
      cnt     <= CNT_W'(1);
    end else if (shift && (cnt != '0)) begin
      if (cnt == LAST) begin
        bit_out <= 1'b0;
        sreg    <= '0;
        cnt     <= '0;
      end else begin
        bit_out <= sreg[DATA_W-1];
        sreg    <= {sreg[DATA_W-2:0], 1'b0};
        cnt     <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_slave_gen2.sv
// spi_slave_gen2: SPI slave framing controller.
// A frame is one command bit used for routing, followed by FRAME_W bits
// (command repeated in the MSB, then payload) shifted MSB-first into rx_data.
// A read-address frame arms rd_addr_hold; the next read frame becomes a
// read-data frame that waits for tx_valid and returns tx_data on MISO.
// Optional: define SPI_SLAVE_FRAME_ERR_EN to add the frame_err abort flag.
module spi_slave_gen2
  import spi_slave_pkg::*;
#(
  parameter  int DATA_W  = 8,
  localparam int FRAME_W = DATA_W + 2
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               MOSI,
  input  logic               SS_n,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic               frame_err
`endif
);

  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] FRAME_END  = CNT_W'(FRAME_W);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;       // saturates at FRAME_END once a frame is in
  logic             rd_addr_hold;  // a read address is pending its data phase
  logic             tx_wait;       // read-data frame done, waiting for tx_valid
  logic             tx_load;
  logic             tx_shift;
  logic             tx_done;

  assign tx_load  = (state == READ_DATA) && tx_wait && tx_valid && !SS_n;
  assign tx_shift = (state == READ_DATA) && !SS_n;

  // Deselect clears the shifter, which both aborts a read and forces MISO low.
  spi_tx_shifter #(.DATA_W(DATA_W)) u_tx (
    .clk     (clk),
    .arst_n  (arst_n),
    .clr     (SS_n),
    .load    (tx_load),
    .shift   (tx_shift),
    .data    (tx_data),
    .bit_out (MISO),
    .done    (tx_done)
  );

  // Frame sequencing: routing, bit capture, rx strobe and read-address tracking.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_hold <= 1'b0;
      tx_wait      <= 1'b0;
    end else begin
      // NOTE: default-low here turns rx_valid into a one-cycle strobe; only the
      // completing edge below raises it.
      rx_valid <= 1'b0;
      // Retire the pending read on the edge that drives the final MISO bit.
      if (tx_done) rd_addr_hold <= 1'b0;

      if ((state != IDLE) && SS_n) begin
        state   <= IDLE;
        bit_cnt <= '0;
        tx_wait <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            if (!SS_n) state <= CHK_CMD;
          end
          CHK_CMD: begin
            if (MOSI == RD_ADDR[1]) state <= rd_addr_hold ? READ_DATA : READ_ADD;
            else                    state <= WRITE;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (bit_cnt != FRAME_END) begin
              rx_data <= {rx_data[FRAME_W-2:0], MOSI};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == FRAME_LAST) begin
                rx_valid <= 1'b1;
                if (state == READ_ADD)  rd_addr_hold <= 1'b1;
                if (state == READ_DATA) tx_wait      <= 1'b1;
              end
            end else if (tx_load) begin
              tx_wait <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic in_frame;
  logic pending;
  logic abort;

  // Work still owed: frame bits outstanding, or a read-data frame whose
  // MISO phase has not finished (rd_addr_hold stays set until its last bit).
  assign in_frame = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  assign pending  = (bit_cnt != FRAME_END) || ((state == READ_DATA) && rd_addr_hold);
  assign abort    = SS_n && in_frame && pending;

  // One-cycle flag for each deselect that cuts a transaction short.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) frame_err <= 1'b0;
    else         frame_err <= abort;
  end
`endif

endmodule

// File: tb/tb_spi_slave_gen2.sv
// tb_spi_slave_gen2: self-checking bench for spi_slave_gen2 at DATA_W=8 and 16.
// Directed vector table, hand-written reset sequence, then random transactions
// checked against a transaction-level model of the read-address handshake.
`timescale 1ns/1ps
module tb_spi_slave_gen2;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ss8 = 1'b1, mosi8 = 1'b0, txv8 = 1'b0;
  logic [7:0]  txd8 = '0;
  logic        miso8, rxv8;
  logic [9:0]  rxd8;
  logic        ss16 = 1'b1, mosi16 = 1'b0, txv16 = 1'b0;
  logic [15:0] txd16 = '0;
  logic        miso16, rxv16;
  logic [17:0] rxd16;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic        fe8, fe16;
`endif

  spi_slave_gen2 #(.DATA_W(8)) dut8 (
    .clk(clk), .arst_n(arst_n), .MOSI(mosi8), .SS_n(ss8),
    .tx_data(txd8), .tx_valid(txv8), .MISO(miso8),
    .rx_data(rxd8), .rx_valid(rxv8)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , .frame_err(fe8)
`endif
  );

  spi_slave_gen2 #(.DATA_W(16)) dut16 (
    .clk(clk), .arst_n(arst_n), .MOSI(mosi16), .SS_n(ss16),
    .tx_data(txd16), .tx_valid(txv16), .MISO(miso16),
    .rx_data(rxd16), .rx_valid(rxv16)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , .frame_err(fe16)
`endif
  );

  typedef struct {
    int          w;           // DATA_W of the targeted instance
    logic        cmd;         // routing bit sent during CHK_CMD
    logic [31:0] frame;       // FRAME_W-bit frame, MSB first
    int          abort_bits;  // frame bits sent before SS_n rises; -1 = none
    int          tx_delay;    // idle cycles before the tx_valid pulse
    logic [31:0] tx_word;
    int          miso_bits;   // MISO samples before SS_n rises; 0 = full
  } vin_t;

  typedef struct {
    logic        rxv;
    logic [31:0] rx;
    int          nbits;       // MISO bits of tx_word expected
    logic        ferr;
  } vexp_t;

  typedef struct {
    vin_t  i;
    vexp_t e;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Observation accumulators, refreshed per transaction.
  int   cyc, rxv_cnt, rxv_cyc, fe_cnt, stray;
  logic [31:0] rxd_at;
  logic in_trace;

  // Model state: pending read address per instance (0: DATA_W=8, 1: 16).
  logic hold_m [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic ss, input logic mosi);
    if (w == 8) begin ss8 = ss; mosi8 = mosi; end
    else        begin ss16 = ss; mosi16 = mosi; end
  endtask

  task automatic set_tx(input int w, input logic v, input logic [31:0] d);
    if (w == 8) begin txv8 = v; txd8 = d[7:0]; end
    else        begin txv16 = v; txd16 = d[15:0]; end
  endtask

  function automatic logic s_rxv(input int w);
    return (w == 8) ? rxv8 : rxv16;
  endfunction

  function automatic logic [31:0] s_rxd(input int w);
    return (w == 8) ? 32'(rxd8) : 32'(rxd16);
  endfunction

  function automatic logic s_miso(input int w);
    return (w == 8) ? miso8 : miso16;
  endfunction

  function automatic logic s_fe(input int w);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    return (w == 8) ? fe8 : fe16;
`else
    return (w == 8) ? 1'b0 : 1'b0;
`endif
  endfunction

  // One clock: DUT samples on posedge, bench observes on the following negedge.
  task automatic tick(input int w);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (s_rxv(w)) begin rxv_cnt++; rxv_cyc = cyc; rxd_at = s_rxd(w); end
    if (s_fe(w)) fe_cnt++;
    if (!in_trace && s_miso(w)) stray++;
  endtask

  function automatic vec_t mk(input int w, input logic cmd, input logic [31:0] fr,
                              input int ab, input int dl, input logic [31:0] tx, input int mb,
                              input logic rxv, input logic [31:0] rx, input int nb, input logic fe);
    vec_t v;
    v.i.w = w; v.i.cmd = cmd; v.i.frame = fr; v.i.abort_bits = ab;
    v.i.tx_delay = dl; v.i.tx_word = tx; v.i.miso_bits = mb;
    v.e.rxv = rxv; v.e.rx = rx; v.e.nbits = nb; v.e.ferr = fe;
    return v;
  endfunction

  // Transaction-level reference: routing from the pending-address flag only.
  task automatic model(input vin_t v, output vexp_t e);
    int idx;
    idx = (v.w == 8) ? 0 : 1;
    e.rxv = 1'b0; e.rx = '0; e.nbits = 0; e.ferr = 1'b0;
    if (v.abort_bits >= 0) begin
      e.ferr = 1'b1;
    end else begin
      e.rxv = 1'b1;
      e.rx  = v.frame;
      if (v.cmd) begin
        if (!hold_m[idx]) begin
          hold_m[idx] = 1'b1;
        end else begin
          e.nbits = (v.miso_bits == 0) ? v.w : v.miso_bits;
          if (e.nbits == v.w) hold_m[idx] = 1'b0;
          else                e.ferr = 1'b1;
        end
      end
    end
  endtask

  // Drive one complete transaction and compare everything observed.
  task automatic run_vec(input vin_t v, input vexp_t e, input string tag);
    int fw;
    logic [33:0] trace, exp_trace;
    fw = v.w + 2;
    trace = '0;
    rxv_cnt = 0; fe_cnt = 0; stray = 0; cyc = -1; rxv_cyc = -1; rxd_at = '0; in_trace = 1'b0;
    drive(v.w, 1'b0, 1'b0);  tick(v.w);     // select: enter CHK_CMD
    drive(v.w, 1'b0, v.cmd); tick(v.w);     // routing bit
    for (int j = 0; j < fw; j++) begin
      if (j == v.abort_bits) begin
        drive(v.w, 1'b1, 1'b0);
        tick(v.w);
        break;
      end
      drive(v.w, 1'b0, v.frame[fw-1-j]);
      tick(v.w);
    end
    if (v.abort_bits < 0) begin
      drive(v.w, 1'b0, 1'b0);
      for (int d = 0; d < v.tx_delay; d++) tick(v.w);
      set_tx(v.w, 1'b1, v.tx_word);
      in_trace = 1'b1;
      tick(v.w);
      set_tx(v.w, 1'b0, $urandom);
      trace = {trace[32:0], s_miso(v.w)};
      for (int i = 1; i < v.w + 2; i++) begin
        if (i == v.miso_bits) drive(v.w, 1'b1, 1'b0);
        tick(v.w);
        trace = {trace[32:0], s_miso(v.w)};
      end
      in_trace = 1'b0;
    end
    drive(v.w, 1'b1, 1'b0);
    tick(v.w);
    tick(v.w);

    exp_trace = '0;
    for (int i = 0; i < v.w + 2; i++)
      exp_trace = {exp_trace[32:0], (i < e.nbits) ? v.tx_word[v.w-1-i] : 1'b0};

    check({tag, " rx_valid count"}, 64'(rxv_cnt), 64'(e.rxv));
    if (e.rxv) begin
      check({tag, " rx_valid cycle"}, 64'(rxv_cyc), 64'(fw + 1));
      check({tag, " rx_data"}, 64'(rxd_at), 64'(e.rx));
      check({tag, " rx_data held"}, 64'(s_rxd(v.w)), 64'(e.rx));
    end
    check({tag, " miso trace"}, 64'(trace), 64'(exp_trace));
    check({tag, " stray miso"}, 64'(stray), 64'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check({tag, " frame_err"}, 64'(fe_cnt), 64'(e.ferr));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " miso8"}, 64'(miso8), 64'd0);
    check({tag, " rx_valid8"}, 64'(rxv8), 64'd0);
    check({tag, " rx_data8"}, 64'(rxd8), 64'd0);
    check({tag, " miso16"}, 64'(miso16), 64'd0);
    check({tag, " rx_valid16"}, 64'(rxv16), 64'd0);
    check({tag, " rx_data16"}, 64'(rxd16), 64'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check({tag, " frame_err8"}, 64'(fe8), 64'd0);
    check({tag, " frame_err16"}, 64'(fe16), 64'd0);
`endif
  endtask

  vec_t  tbl [13];
  vin_t  rv;
  vexp_t re, dummy;
  logic [33:0] mtrace;

  initial begin
    hold_m[0] = 1'b0;
    hold_m[1] = 1'b0;

    //         w  cmd frame     abort dly tx        mb   rxv rx        nb  ferr
    tbl[0]  = mk(8,  0, 32'h0A5,   -1, 0, 32'h00,   0,   1, 32'h0A5,   0,  0);
    tbl[1]  = mk(8,  1, 32'h203,   -1, 1, 32'h77,   0,   1, 32'h203,   0,  0);
    tbl[2]  = mk(8,  1, 32'h35A,   -1, 1, 32'hC3,   0,   1, 32'h35A,   8,  0);
    tbl[3]  = mk(8,  1, 32'h3FF,   -1, 0, 32'h81,   0,   1, 32'h3FF,   0,  0);
    tbl[4]  = mk(8,  0, 32'h0A5,    5, 0, 32'h00,   0,   0, 32'h000,   0,  1);
    tbl[5]  = mk(8,  0, 32'h1FF,   -1, 2, 32'hFF,   0,   1, 32'h1FF,   0,  0);
    tbl[6]  = mk(8,  1, 32'h300,   -1, 0, 32'h5A,   3,   1, 32'h300,   3,  1);
    tbl[7]  = mk(8,  1, 32'h3C3,   -1, 2, 32'hA5,   0,   1, 32'h3C3,   8,  0);
    tbl[8]  = mk(16, 0, 32'h0A5C3, -1, 0, 32'h0,    0,   1, 32'h0A5C3, 0,  0);
    tbl[9]  = mk(16, 1, 32'h20003, -1, 0, 32'h11,   0,   1, 32'h20003, 0,  0);
    tbl[10] = mk(16, 1, 32'h3ABCD, -1, 0, 32'hC3C3, 0,   1, 32'h3ABCD, 16, 0);
    tbl[11] = mk(16, 1, 32'h3ABCD, -1, 0, 32'hFFFF, 0,   1, 32'h3ABCD, 0,  0);
    tbl[12] = mk(16, 0, 32'h00000,  0, 0, 32'h0,    0,   0, 32'h00000, 0,  1);

    // Reset state.
    #12;
    check_all_zero("reset");
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);

    // Directed vectors.
    for (int k = 0; k < 13; k++) begin
      model(tbl[k].i, dummy);
      run_vec(tbl[k].i, tbl[k].e, $sformatf("vec%0d", k));
    end

    // Reset in the middle of a MISO shift, then confirm the pending address is gone.
    rv = mk(8, 1, 32'h2AA, -1, 0, 32'h0, 0, 0, 32'h0, 0, 0).i;
    model(rv, re);
    run_vec(rv, re, "rst_pre_addr");
    rxv_cnt = 0; fe_cnt = 0; stray = 0; cyc = -1; in_trace = 1'b0; mtrace = '0;
    drive(8, 1'b0, 1'b0); tick(8);
    drive(8, 1'b0, 1'b1); tick(8);
    for (int j = 0; j < 10; j++) begin
      drive(8, 1'b0, (j < 2) ? 1'b1 : 1'b0);
      tick(8);
    end
    set_tx(8, 1'b1, 32'hC3);
    in_trace = 1'b1;
    tick(8);
    set_tx(8, 1'b0, 32'h0);
    mtrace = {mtrace[32:0], miso8};
    tick(8); mtrace = {mtrace[32:0], miso8};
    tick(8); mtrace = {mtrace[32:0], miso8};
    check("rst_mid rx_valid count", 64'(rxv_cnt), 64'd1);
    check("rst_mid miso first bits", 64'(mtrace), 64'b110);
    #1 arst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    drive(8, 1'b1, 1'b0);
    in_trace = 1'b0;
    arst_n = 1'b1;
    hold_m[0] = 1'b0;
    hold_m[1] = 1'b0;
    @(negedge clk);
    rv = mk(8, 1, 32'h3C3, -1, 0, 32'hC3, 0, 0, 32'h0, 0, 0).i;
    model(rv, re);
    run_vec(rv, re, "rst_post");

    // Random transactions against the model.
    for (int k = 0; k < 40; k++) begin
      int fw;
      rv.w = ($urandom_range(0, 1) == 1) ? 16 : 8;
      fw = rv.w + 2;
      rv.cmd = 1'($urandom_range(0, 1));
      rv.frame = $urandom & ((32'h1 << fw) - 32'h1);
      rv.frame[fw-1] = rv.cmd;
      rv.abort_bits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, fw - 1)) : -1;
      rv.tx_delay = $urandom_range(0, 3);
      rv.tx_word = $urandom & ((32'h1 << rv.w) - 32'h1);
      rv.miso_bits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, rv.w - 1)) : 0;
      model(rv, re);
      run_vec(rv, re, $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
